buffer_fifo: RTL
================

# buffer_fifo

Parametrised synchronous FIFO for the peripheral bandwidth path. It is the successor to the fixed dual-port RAM with free-running pointers. It adds full/empty gating, programmable almost-full/almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags. It sits between a peripheral-side producer and a bus-side consumer and absorbs rate mismatch within one clock domain.

## Interface
- DATA_WIDTH, 32, payload bits per word
- DEPTH, 16, entries; power of two, ≥ 4
- AFULL_THRESH, DEPTH-2, almost_full asserts when level ≥ this
- AEMPTY_THRESH, 2, almost_empty asserts when level ≤ this
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, synchronous, active-high
- wr_en  in  1  write request
- wr_data  in  DATA_WIDTH  write payload
- full  out  1  no free entry
- almost_full  out  1  level ≥ AFULL_THRESH
- rd_en  in  1  read request
- rd_data  out  DATA_WIDTH  registered read data
- rd_valid  out  1  rd_data updated this cycle
- empty  out  1  no stored entry
- almost_empty  out  1  level ≤ AEMPTY_THRESH
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write attempted while full and not simultaneously read
- underflow  out  1  sticky: read attempted while empty
- clr_err  in  1  clears overflow/underflow

## Operation
- Pointers wr_ptr/rd_ptr are $clog2(DEPTH)+1 bits; the low bits address storage and the MSB is the wrap bit; they increment modulo 2·DEPTH.
- full = (addr bits equal) and (MSBs differ); empty = pointers equal; level = wr_ptr − rd_ptr (unsigned, modulo 2·DEPTH).
- Accept rules: rd_acc = rd_en & ~empty; wr_acc = wr_en & (~full | rd_acc).
- Full with wr_en and rd_en in the same cycle: both are accepted and level is unchanged.
- Empty with wr_en and rd_en in the same cycle: only the write is accepted and underflow sets.
- Rejected write: storage and pointers are unchanged and overflow sets. Rejected read: rd_data holds, rd_valid=0 and underflow sets.
- Error flags are sticky until clr_err. If clr_err coincides with a new error, the error wins and the flag stays 1.
- Storage contents are not reset; only control state is.
- No state machine beyond the pointers. All flags are registered, derived from the next-state pointers so they are coherent with level.

## Timing
- Reset values: pointers 0, level 0, empty 1, full 0, almost_empty 1, almost_full 0, rd_data 0, rd_valid 0, overflow 0, underflow 0, parity_err 0.
- Write: data accepted at edge N is readable at edge N+1. There is no fall-through, and rd_en at N+1 sees empty=0.
- Read latency is 1: rd_acc at edge N gives rd_data/rd_valid at N+1. rd_valid is a one-cycle pulse per accepted read.
- Flags and level update at the same edge as the accepted operation.
- Reset mid-operation: at the next edge all control state returns to reset values and in-flight rd_valid is dropped; stale contents are unreachable.

## Configuration
- Macro BUFFER_FIFO_PARITY_EN.
- Defined:
  - Storage is DATA_WIDTH+1 bits, with even parity over wr_data stored per word.
  - Extra input par_inject (1 bit): when high with an accepted write, the inverted parity bit is stored.
  - Extra output parity_err (1 bit) pulses with rd_valid when recomputed parity ≠ stored parity, and is 0 otherwise.
- Undefined: storage is DATA_WIDTH bits, the par_inject/parity_err ports are absent, and there is no added latency.

## Structure
- Package buffer_pkg:
  - ptr_t/level_t width helper function (clog2-based).
  - Default threshold constants.
  - PARITY_W constant (1 or 0 per the macro).
- One sub-module, buffer_ram: simple dual-port storage with a synchronous write port and a registered read port, no reset, width DATA_WIDTH+PARITY_W.
- Pointer, flag and error logic live in buffer_fifo.

## Test plan
- DATA_WIDTH=16, DEPTH=8: reset, write 0x0001..0x0008 → full=1, level=8, almost_full=1 at level 6. Read 8 times → rd_data 0x0001..0x0008 in order, one cycle after each rd_en, then empty=1.
- Full FIFO, wr_en=1 alone with 0xDEAD → overflow=1, level=8, and 0xDEAD is never read. clr_err → overflow=0.
- Empty FIFO, rd_en=1 → underflow=1, rd_valid=0, rd_data holds its previous value. Same-cycle wr_en 0x0055 with rd_en when empty → level=1, underflow=1.
- Full FIFO, wr_en+rd_en together for 20 cycles with an incrementing pattern → level stays 8, the output sequence is contiguous, and no error flags set (pointer wrap exercised).
- Mid-stream rst with level=5 → next cycle level=0, empty=1, rd_valid=0. Write 0x1234, read → 0x1234.
- With BUFFER_FIFO_PARITY_EN: write 0x00FF with par_inject=1 → parity_err=1 on its rd_valid. The neighbouring words read with parity_err=0.

Source files
------------

// File: rtl/buffer_pkg.sv
// Shared constants and width helpers for the buffer_fifo slice.
// Latency: n/a (package only).
// Backpressure: n/a; PARITY_W follows the BUFFER_FIFO_PARITY_EN macro.
package buffer_pkg;

  // Default almost-empty threshold (level <= this raises almost_empty).
  localparam int DEF_AEMPTY_THRESH = 2;

  // Default distance of the almost-full threshold below DEPTH.
  localparam int DEF_AFULL_MARGIN = 2;

  // Extra storage bit per word carrying even parity when protection is built in.
`ifdef BUFFER_FIFO_PARITY_EN
  localparam int PARITY_W = 1;
`else
  localparam int PARITY_W = 0;
`endif

  // Pointer and level width: address bits plus one wrap bit, so 0..DEPTH fits.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/buffer_ram.sv
// Simple dual-port storage: synchronous write port, registered read port, no reset.
// Latency: write visible to a read issued on the following edge; read data 1 cycle after rd_en.
// Backpressure: none; the owner gates wr_en/rd_en, and rd_data holds when rd_en is low.
module buffer_ram #(
  parameter int WIDTH = 32,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [2**AW];

  // Write port: contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port: output register loads only on a granted read, otherwise it holds.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/buffer_fifo.sv
// Synchronous FIFO with full/empty gating, thresholds, level and sticky errors; optional parity via BUFFER_FIFO_PARITY_EN.
// Latency: write readable on the next edge (no fall-through); rd_data/rd_valid 1 cycle after an accepted read.
// Backpressure: writes refused when full unless a read is accepted in the same cycle; refused ops set sticky flags.
module buffer_fifo
  import buffer_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = DEPTH - DEF_AFULL_MARGIN,
  parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          full,
  output logic                          almost_full,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          rd_valid,
  output logic                          empty,
  output logic                          almost_empty,
  output logic [ptr_width(DEPTH)-1:0]   level,
  output logic                          overflow,
  output logic                          underflow,
`ifdef BUFFER_FIFO_PARITY_EN
  input  logic                          par_inject,
  output logic                          parity_err,
`endif
  input  logic                          clr_err
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;
  localparam int MW = DATA_WIDTH + PARITY_W;

  localparam logic [PW-1:0] AF_T = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AE_T = PW'(AEMPTY_THRESH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr_nxt;
  logic [PW-1:0] rd_ptr_nxt;
  logic [PW-1:0] level_nxt;
  logic          full_nxt;
  logic          empty_nxt;
  logic          rd_acc;
  logic          wr_acc;
  logic          ovf_evt;
  logic          unf_evt;
  logic          rd_seen;
  logic [MW-1:0] wr_word;
  logic [MW-1:0] ram_q;

  // Accept decisions use the registered flags, which always match the pointers.
  assign rd_acc  = rd_en & ~empty;
  assign wr_acc  = wr_en & (~full | rd_acc);
  assign ovf_evt = wr_en & full & ~rd_acc;
  assign unf_evt = rd_en & empty;

  // Next-state pointers and the flags derived from them, so flags land with level.
  always_comb begin
    wr_ptr_nxt = wr_ptr + PW'(wr_acc);
    rd_ptr_nxt = rd_ptr + PW'(rd_acc);
    level_nxt  = wr_ptr_nxt - rd_ptr_nxt;
    empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);
    full_nxt   = (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]) &&
                 (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]);
  end

  // Pointer, level and flag registers; reset returns all control state to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      level        <= level_nxt;
      empty        <= empty_nxt;
      full         <= full_nxt;
      almost_empty <= (level_nxt <= AE_T);
      almost_full  <= (level_nxt >= AF_T);
    end
  end

  // Sticky error flags; a new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_evt) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (unf_evt) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

  // Read handshake: rd_valid pulses per accepted read; rd_seen masks the unreset RAM output.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_seen  <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      rd_seen  <= rd_seen | rd_acc;
    end
  end

`ifdef BUFFER_FIFO_PARITY_EN
  // Even parity stored alongside the payload; par_inject deliberately corrupts it.
  assign wr_word    = {(^wr_data) ^ par_inject, wr_data};
  assign parity_err = rd_valid & ((^ram_q[DATA_WIDTH-1:0]) != ram_q[DATA_WIDTH]);
`else
  assign wr_word    = wr_data;
`endif

  // Until the first read after reset the output reads as zero.
  assign rd_data = rd_seen ? ram_q[DATA_WIDTH-1:0] : '0;

  buffer_ram #(
    .WIDTH (MW),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (wr_word),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (ram_q)
  );

endmodule
